// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI command frame decoder.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    GET_CMD,
    GET_ADDR,
    GET_LEN,
    GET_DATA,
    GET_CHK,
    COMMIT
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CMD     = 3'd1,
    ERR_LEN     = 3'd2,
    ERR_CHK     = 3'd3,
    ERR_TRUNC   = 3'd4,
    ERR_OVERRUN = 3'd5
  } err_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CMD_WR_DEF    = 8'h01;

  // Index width for a buffer of the given depth; a depth of 1 still needs one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spi_frame_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module spi_frame_buf
  import spi_frame_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = idx_w(MAX_LEN)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_frame_decoder.sv
// Parses SYNC/CMD/ADDR/LEN/payload/CHK frames from the SPI byte stream and
// replays verified payloads as register writes over a valid/ready port.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [7:0] CMD_WR    = CMD_WR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_en,
  input  logic [7:0] byte_data,
  input  logic       spi_ss,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int AW = idx_w(MAX_LEN);

  state_t     state;
  logic       ss_d0;
  logic [7:0] len;
  logic [7:0] wptr;
  logic [7:0] rptr;
  logic [7:0] base_addr;
  logic [7:0] csum;
  logic       ovr_pend;
  logic [7:0] rdata;

  logic       ss_rise;
  logic       in_frame;
  logic       cmd_bad;
  logic       len_bad;
  logic       chk_byte;
  logic       trunc;
  logic       handshake;
  logic       last_beat;
  logic       buf_we;
  logic [7:0] rptr_nxt;

  assign ss_rise   = !ss_d0 && spi_ss;
  assign in_frame  = state inside {GET_CMD, GET_ADDR, GET_LEN, GET_DATA, GET_CHK};
  assign cmd_bad   = byte_en && (state == GET_CMD) && (byte_data != CMD_WR);
  assign len_bad   = byte_en && (state == GET_LEN) &&
                     ((byte_data == 8'd0) || (int'(byte_data) > MAX_LEN));
  assign chk_byte  = byte_en && (state == GET_CHK);
  // A byte landing with the ss edge is judged first; only a byte that does not
  // itself end the frame lets the edge count as a truncation.
  assign trunc     = ss_rise && in_frame && !cmd_bad && !len_bad && !chk_byte;
  assign handshake = (state == COMMIT) && wr_en && wr_ready;
  assign last_beat = handshake && ((rptr + 8'd1) == len);
  assign buf_we    = byte_en && (state == GET_DATA);
  assign rptr_nxt  = (state == COMMIT) ? rptr + 8'd1 : 8'd0;
  assign busy      = (state != HUNT);

  spi_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wptr[AW-1:0]),
    .wdata (byte_data),
    .raddr (rptr_nxt[AW-1:0]),
    .rdata (rdata)
  );

  // Checksum and base address are pure datapath; framing logic qualifies their use.
  always_ff @(posedge clk) begin
    if (state == HUNT && byte_en && byte_data == SYNC_BYTE)
      csum <= '0;
    else if (byte_en && state inside {GET_CMD, GET_ADDR, GET_LEN, GET_DATA})
      csum <= csum ^ byte_data;
    if (state == GET_ADDR && byte_en)
      base_addr <= byte_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      ss_d0     <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      len       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      ovr_pend  <= 1'b0;
    end else begin
      ss_d0     <= spi_ss;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      ovr_pend  <= 1'b0;
      if (ovr_pend) begin
        frame_err <= 1'b1;
        err_code  <= ERR_OVERRUN;
      end
      if (trunc) begin
        state     <= HUNT;
        frame_err <= 1'b1;
        err_code  <= ERR_TRUNC;
      end else begin
        case (state)
          HUNT: begin
            if (byte_en && byte_data == SYNC_BYTE) state <= GET_CMD;
          end
          GET_CMD: begin
            if (cmd_bad) begin
              state     <= HUNT;
              frame_err <= 1'b1;
              err_code  <= ERR_CMD;
            end else if (byte_en) begin
              state <= GET_ADDR;
            end
          end
          GET_ADDR: begin
            if (byte_en) state <= GET_LEN;
          end
          GET_LEN: begin
            if (len_bad) begin
              state     <= HUNT;
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end else if (byte_en) begin
              len   <= byte_data;
              wptr  <= '0;
              state <= GET_DATA;
            end
          end
          GET_DATA: begin
            if (byte_en) begin
              wptr <= wptr + 8'd1;
              if ((wptr + 8'd1) == len) state <= GET_CHK;
            end
          end
          GET_CHK: begin
            if (byte_en) begin
              if (byte_data == csum) begin
                state   <= COMMIT;
                rptr    <= '0;
                wr_en   <= 1'b1;
                wr_addr <= base_addr;
                wr_data <= rdata;
              end else begin
                state     <= HUNT;
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
              end
            end
          end
          COMMIT: begin
            // An overrun colliding with frame_ok is reported one cycle later.
            if (byte_en) begin
              if (last_beat) begin
                ovr_pend <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_OVERRUN;
              end
            end
            if (handshake) begin
              if (last_beat) begin
                wr_en    <= 1'b0;
                frame_ok <= 1'b1;
                state    <= HUNT;
              end else begin
                rptr    <= rptr_nxt;
                wr_addr <= wr_addr + 8'd1;
                wr_data <= rdata;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: frame vector table plus hand-written sequences.
module tb_spi_frame_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_en;
  logic [7:0] byte_data;
  logic       spi_ss;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int n_wr, n_ok, n_ferr;
  bit both;
  logic [15:0] wq[$];

  typedef struct {
    logic [95:0] bytes;
    int          n;
    bit          ss_end;
    int          exp_wr;
    int          exp_ok;
    int          exp_ferr;
    logic [2:0]  exp_code;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] bp_data[3];

  always #5 clk = ~clk;

  spi_frame_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .byte_en   (byte_en),
    .byte_data (byte_data),
    .spi_ss    (spi_ss),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (wr_en && wr_ready) begin
      wq.push_back({wr_addr, wr_data});
      n_wr++;
    end
    if (frame_ok) n_ok++;
    if (frame_err) n_ferr++;
    if (frame_ok && frame_err) both = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_wr = 0;
    n_ok = 0;
    n_ferr = 0;
    both = 1'b0;
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    byte_en = 1'b1;
    byte_data = b;
    @(posedge clk);
    #1;
    byte_en = 1'b0;
  endtask

  task automatic send_frame(input logic [95:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b[95-8*i -: 8]);
  endtask

  initial begin
    vecs[0] = '{96'hA5_01_10_03_11_22_33_12_00_00_00_00, 8, 1'b0, 3, 1, 0, 3'd0, 16'h1011, 16'h1233};
    vecs[1] = '{96'h00_5A_A5_01_10_03_11_22_33_13_00_00, 10, 1'b0, 0, 0, 1, 3'd3, 16'h0, 16'h0};
    vecs[2] = '{96'hA5_01_10_03_11_22_33_12_00_00_00_00, 8, 1'b0, 3, 1, 0, 3'd3, 16'h1011, 16'h1233};
    vecs[3] = '{96'hA5_01_00_00_00_00_00_00_00_00_00_00, 4, 1'b0, 0, 0, 1, 3'd2, 16'h0, 16'h0};
    vecs[4] = '{96'hA5_01_00_11_00_00_00_00_00_00_00_00, 4, 1'b0, 0, 0, 1, 3'd2, 16'h0, 16'h0};
    vecs[5] = '{96'hA5_02_00_00_00_00_00_00_00_00_00_00, 2, 1'b0, 0, 0, 1, 3'd1, 16'h0, 16'h0};
    vecs[6] = '{96'hA5_01_20_04_AA_BB_00_00_00_00_00_00, 6, 1'b1, 0, 0, 1, 3'd4, 16'h0, 16'h0};
    vecs[7] = '{96'hA5_01_FF_02_AA_BB_ED_00_00_00_00_00, 7, 1'b0, 2, 1, 0, 3'd4, 16'hFFAA, 16'h00BB};
    bp_data[0] = 8'h11;
    bp_data[1] = 8'h22;
    bp_data[2] = 8'h33;

    rst = 1'b1;
    byte_en = 1'b0;
    byte_data = 8'h00;
    spi_ss = 1'b1;
    wr_ready = 1'b1;
    clear_mon();
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spi_ss = 1'b0;
    repeat (2) @(posedge clk);

    // Latency and back-to-back writes with wr_ready held high
    clear_mon();
    send_frame(96'hA5_01_10_03_11_22_33_12_00_00_00_00, 8);
    @(negedge clk);
    chk("lat_en0", 32'(wr_en), 32'd1);
    chk("lat_w0", 32'({wr_addr, wr_data}), 32'h1011);
    @(negedge clk);
    chk("lat_w1", 32'({wr_addr, wr_data}), 32'h1122);
    @(negedge clk);
    chk("lat_w2", 32'({wr_addr, wr_data}), 32'h1233);
    @(negedge clk);
    chk("lat_en_off", 32'(wr_en), 32'd0);
    chk("lat_ok", 32'(frame_ok), 32'd1);
    @(negedge clk);
    chk("lat_ok_pulse", 32'(frame_ok), 32'd0);
    chk("lat_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 8; v++) begin
      clear_mon();
      send_frame(vecs[v].bytes, vecs[v].n);
      if (vecs[v].ss_end) begin
        @(posedge clk);
        #1 spi_ss = 1'b1;
      end
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_writes", v), 32'(n_wr), 32'(vecs[v].exp_wr));
      chk($sformatf("v%0d_frame_ok", v), 32'(n_ok), 32'(vecs[v].exp_ok));
      chk($sformatf("v%0d_frame_err", v), 32'(n_ferr), 32'(vecs[v].exp_ferr));
      chk($sformatf("v%0d_err_code", v), 32'(err_code), 32'(vecs[v].exp_code));
      chk($sformatf("v%0d_ok_err_overlap", v), 32'(both), 32'd0);
      if (vecs[v].exp_wr > 0 && n_wr > 0) begin
        chk($sformatf("v%0d_first_wr", v), 32'(wq[0]), 32'(vecs[v].exp_first));
        chk($sformatf("v%0d_last_wr", v), 32'(wq[$]), 32'(vecs[v].exp_last));
      end
      spi_ss = 1'b0;
    end

    // Backpressure: three stalled cycles per beat
    wr_ready = 1'b0;
    clear_mon();
    send_frame(96'hA5_01_10_03_11_22_33_12_00_00_00_00, 8);
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("bp%0d_en", k), 32'(wr_en), 32'd1);
        chk($sformatf("bp%0d_addr", k), 32'(wr_addr), 32'(8'h10 + 8'(k)));
        chk($sformatf("bp%0d_data", k), 32'(wr_data), 32'(bp_data[k]));
      end
      @(posedge clk);
      #1 wr_ready = 1'b1;
      @(posedge clk);
      #1 wr_ready = 1'b0;
    end
    @(negedge clk);
    chk("bp_en_off", 32'(wr_en), 32'd0);
    chk("bp_ok", 32'(frame_ok), 32'd1);
    repeat (4) @(negedge clk);
    chk("bp_writes", 32'(n_wr), 32'd3);
    chk("bp_ok_count", 32'(n_ok), 32'd1);
    chk("bp_err_count", 32'(n_ferr), 32'd0);

    // Address wrap with an overrun byte during the stalled commit
    clear_mon();
    send_frame(96'hA5_01_FF_02_AA_BB_ED_00_00_00_00_00, 7);
    @(negedge clk);
    chk("ovr_first", 32'({wr_en, wr_addr, wr_data}), 32'h1FFAA);
    send_byte(8'h77);
    @(negedge clk);
    chk("ovr_err_pulse", 32'(frame_err), 32'd1);
    chk("ovr_err_code", 32'(err_code), 32'd5);
    chk("ovr_hold", 32'({wr_en, wr_addr, wr_data}), 32'h1FFAA);
    @(posedge clk);
    #1 wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 wr_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_writes", 32'(n_wr), 32'd2);
    if (n_wr >= 2) begin
      chk("ovr_wr0", 32'(wq[0]), 32'hFFAA);
      chk("ovr_wr1", 32'(wq[1]), 32'h00BB);
    end
    chk("ovr_ok", 32'(n_ok), 32'd1);
    chk("ovr_err_count", 32'(n_ferr), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd0);

    // CHK byte and ss rising edge in the same cycle still commit
    wr_ready = 1'b1;
    clear_mon();
    send_frame(96'hA5_01_20_02_AA_BB_00_00_00_00_00_00, 6);
    @(posedge clk);
    #1;
    byte_en = 1'b1;
    byte_data = 8'h32;
    spi_ss = 1'b1;
    @(posedge clk);
    #1 byte_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("ssc_writes", 32'(n_wr), 32'd2);
    if (n_wr >= 2) begin
      chk("ssc_wr0", 32'(wq[0]), 32'h20AA);
      chk("ssc_wr1", 32'(wq[1]), 32'h21BB);
    end
    chk("ssc_ok", 32'(n_ok), 32'd1);
    chk("ssc_err_count", 32'(n_ferr), 32'd0);
    chk("ssc_err_code", 32'(err_code), 32'd5);
    spi_ss = 1'b0;

    // Asynchronous reset in the middle of a stalled commit
    wr_ready = 1'b0;
    clear_mon();
    send_frame(96'hA5_01_10_03_11_22_33_12_00_00_00_00, 8);
    @(negedge clk);
    chk("rc_en_before", 32'(wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rc_en", 32'(wr_en), 32'd0);
    chk("rc_addr_data", 32'({wr_addr, wr_data}), 32'h0);
    chk("rc_busy", 32'(busy), 32'd0);
    chk("rc_err_code", 32'(err_code), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    wr_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("rc_no_ok", 32'(n_ok), 32'd0);
    chk("rc_no_writes", 32'(n_wr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
